// File: rtl/fifo_pkg.sv
// Shared parameters and state encoding for the FIFO read-side drain engine.
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 8
`endif

package fifo_pkg;

  localparam int WIDTH = `FIFO_WIDTH;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/fifo_rd_drain_chk.sv
// Invariant checks for the drain engine's output buffer.
module fifo_rd_drain_chk (
  input logic       clk,
  input logic       res,
  input logic       push,
  input logic       pop,
  input logic [1:0] occ
);

  // A full buffer must never take a word without releasing one, and an empty one is never popped.
  always @(posedge clk) begin
    if (!res) begin
      assert (!(push && !pop && (occ == 2'd2)));
      assert (!(pop && (occ == 2'd0)));
      assert (occ != 2'd3);
    end
  end

endmodule

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer; the head entry drives the downstream data register.
module fifo_rd_skid #(
  parameter int WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head,
  output logic             valid
);
  import fifo_pkg::*;

  logic [1:0]       occ_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;

  // Entry shuffle; head keeps its last value once the buffer runs dry.
  always_ff @(posedge clk) begin
    if (res) begin
      occ_r  <= 2'd0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (occ_r)
            2'd0: begin
              head_r <= din;
              occ_r  <= 2'd1;
            end
            2'd1: begin
              tail_r <= din;
              occ_r  <= 2'd2;
            end
            default: occ_r <= occ_r;
          endcase
        end
        2'b01: begin
          case (occ_r)
            2'd2: begin
              head_r <= tail_r;
              occ_r  <= 2'd1;
            end
            2'd1: occ_r <= 2'd0;
            default: occ_r <= occ_r;
          endcase
        end
        2'b11: begin
          case (occ_r)
            2'd2: begin
              head_r <= tail_r;
              tail_r <= din;
            end
            2'd1: head_r <= din;
            default: begin
              head_r <= din;
              occ_r  <= 2'd1;
            end
          endcase
        end
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occ   = occ_r;
  assign head  = head_r;
  assign valid = (occ_r != 2'd0);

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pulls a programmed number of words from the FIFO read port
// and presents them on a valid/ready stream, never reading without room for the result.
module fifo_rd_drain #(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int CNT_W = fifo_pkg::CNT_W
) (
  input  logic             rd_clk,
  input  logic             res,
  input  logic             start,
  input  logic [CNT_W-1:0] xfer_len,
  input  logic             abort,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rdata,
  input  logic             empty,
  input  logic             underflow,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_count,
  output logic             err_underflow
);
  import fifo_pkg::*;

  drain_state_t     state_r;
  drain_state_t     state_s;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] rd_count_r;
  logic             inflight_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [1:0]       occ_s;
  logic             pop_s;
  logic             rd_en_s;
  logic             start_ok_s;
  logic [2:0]       fill_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign pop_s      = m_valid && m_ready;
  // Slots committed after this cycle: buffered plus returning, minus the word leaving now.
  assign fill_s     = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign start_ok_s = (state_r == IDLE) && start;

  // Next-state decode and read-issue rule.
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (xfer_len != {CNT_W{1'b0}}) state_s = DRAIN;
          else                           state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        rd_en_s = !empty && (remaining_r != {CNT_W{1'b0}}) && !abort && (fill_s < 3'd2);
        if (abort || (remaining_r == {CNT_W{1'b0}})) state_s = FLUSH;
        else                                         state_s = DRAIN;
      end
      FLUSH: begin
        if (!inflight_r && (occ_s == 2'd0)) state_s = DONE;
        else                                state_s = FLUSH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters and registered status.
  always_ff @(posedge rd_clk) begin
    if (res) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      rd_count_r  <= '0;
      inflight_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_en_s;
      busy_r     <= (state_s == DRAIN) || (state_s == FLUSH);
      done_r     <= (state_s == DONE);
      err_r      <= (err_r && !start_ok_s) || underflow;
      if (start_ok_s) begin
        remaining_r <= xfer_len;
        rd_count_r  <= '0;
      end else if (rd_en_s) begin
        remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
        rd_count_r  <= sat_inc(rd_count_r);
      end else begin
        remaining_r <= remaining_r;
        rd_count_r  <= rd_count_r;
      end
    end
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk   (rd_clk),
    .res   (res),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (rdata),
    .occ   (occ_s),
    .head  (m_data),
    .valid (m_valid)
  );

  fifo_rd_drain_chk u_chk (
    .clk  (rd_clk),
    .res  (res),
    .push (inflight_r),
    .pop  (pop_s),
    .occ  (occ_s)
  );

  assign rd_en         = rd_en_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign rd_count      = rd_count_r;
  assign err_underflow = err_r;

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
Read-side engine for the team's FIFO. It drains a programmed number of words from the FIFO read port and presents them on a valid/ready stream towards downstream logic. It is the read-end counterpart of the write BFM/driver path and sits in the rd_clk domain. It issues rd_en only when it is guaranteed space for the returning word, and it flags FIFO underflow.

Parameters:
WIDTH, 8, data width; equals the codebase `width.
CNT_W, 16, width of the transfer length and word counters.

Ports:
rd_clk  in  1  read-domain clock; all logic on posedge.
res  in  1  reset, synchronous, active-high.
start  in  1  one-cycle pulse; begins a transfer of xfer_len words.
xfer_len  in  CNT_W  word count, sampled on the start cycle.
abort  in  1  stop issuing new reads; drain in-flight words, then finish.
rd_en  out  1  FIFO read enable.
rdata  in  WIDTH  FIFO read data, valid 1 cycle after rd_en.
empty  in  1  FIFO empty.
underflow  in  1  FIFO underflow indication.
m_valid  out  1  downstream data valid.
m_data  out  WIDTH  downstream data.
m_ready  in  1  downstream ready.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse at transfer end.
rd_count  out  CNT_W  reads issued in the current or last transfer.
err_underflow  out  1  sticky underflow flag.

Behaviour:
- Clocking and reset: one clock, rd_clk. res is synchronous and active-high. res high at an edge forces the following regardless of state:
  - state IDLE, buffer empty, in-flight flag 0;
  - rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, err_underflow=0.
  - Data in flight at reset is discarded.
- States are IDLE, DRAIN, FLUSH, DONE.
- IDLE:
  - start=1 with xfer_len!=0 -> DRAIN. Latch remaining=xfer_len, clear rd_count and err_underflow, busy=1 from the next cycle.
  - start=1 with xfer_len==0 -> DONE, with no reads issued.
  - start is ignored in every other state.
- DRAIN, read issue rule: rd_en = !empty && remaining!=0 && !abort && (occ + inflight - pop) < 2.
  - occ is buffer occupancy, 0..2.
  - inflight is set by rd_en in the previous cycle.
  - pop = m_valid && m_ready.
  - rd_en is combinational from registered state plus empty, m_ready and abort.
- DRAIN, on each rd_en cycle: remaining decrements and rd_count increments, saturating at all-ones.
- DRAIN exit: remaining==0 or abort -> FLUSH.
- Read latency: rdata is captured into the buffer at the edge after the rd_en cycle, i.e. the cycle inflight=1.
  - Capture and pop in the same cycle are both performed.
  - The buffer never overflows by construction. An assertion covers this.
- FLUSH: wait until inflight==0 && occ==0, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- Output buffer: 2-entry FIFO ordering. m_valid = occ!=0; m_data = head entry, registered.
  - m_data holds its value while m_valid && !m_ready.
  - When occ==0, m_data retains its last value.
- Throughput: 1 word/cycle sustained with m_ready=1 and empty=0. First m_valid appears 2 cycles after the first rd_en.
- Underflow: underflow=1 in any cycle sets err_underflow. The flag clears only on res or on an accepted start. If empty is reported correctly, no read is issued while empty.
- Abort: takes effect combinationally on rd_en in the same cycle. Words already in flight or buffered are still delivered.
- rd_count holds after DONE until the next accepted start.

Decomposition:
- Package fifo_pkg:
  - WIDTH default derived from `width;
  - CNT_W;
  - typedef enum logic[1:0] drain_state_t {IDLE, DRAIN, FLUSH, DONE}.
- Sub-module fifo_rd_skid: 2-entry buffer.
  - Inputs: push/pop/data. Outputs: occ, head data, valid.
  - Reset: synchronous, active-high.
- The top level holds the FSM, counters and the rd_en rule.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33; start, xfer_len=3, m_ready=1 -> rd_en high 3 consecutive cycles; m_data 0x11,0x22,0x33 on 3 consecutive cycles starting 2 cycles after the first rd_en; done 1 cycle; rd_count=3; busy low after done.
2. FIFO preloaded with 4 words; xfer_len=4; m_ready=0 for 10 cycles, then 1 -> exactly 2 rd_en pulses while stalled; m_data holds first word; all 4 delivered in order after release.
3. FIFO empty at start, xfer_len=2; write 0xA5 at cycle 5 and 0x5A at cycle 9 -> rd_en only when empty=0; both words delivered; done after the second; err_underflow=0.
4. xfer_len=8 with 8 words available; abort asserted after 3 rd_en -> no further rd_en; 3 words delivered; done pulses; rd_count=3.
5. Inject underflow=1 for 1 cycle mid-transfer -> err_underflow=1 and stays 1 through done; next start clears it to 0.
6. res asserted while occ=2 and inflight=1 -> next cycle all outputs are 0 and state is IDLE; subsequent start, xfer_len=1 completes normally. Also start with xfer_len=0 -> done pulse with no rd_en.
